// File: rtl/pt_pkg.sv
// rtl/pt_pkg.sv - shared constants and types for the PT2262 transmit scheduler
package pt_pkg;

    localparam int PT_CODE_W       = 24;
    localparam int PT_FRAME_CYCLES = 512;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        SEND,
        GAP
    } pt_state_e;

    localparam logic [1:0] PT_TRIT_ZERO  = 2'b00;
    localparam logic [1:0] PT_TRIT_ONE   = 2'b01;
    localparam logic [1:0] PT_TRIT_FLOAT = 2'b10;

endpackage

// File: rtl/pt_tx_sched_rr_arb2.sv
// rtl/pt_tx_sched_rr_arb2.sv - two-way round-robin arbiter with last-grant register
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // last_q holds the index granted most recently; reset to 1 so req0 wins first
    logic last_q;
    logic last_d;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
        last_d = last_q;
        if (gnt[0]) begin
            last_d = 1'b0;
        end else if (gnt[1]) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/pt_tx_sched.sv
// rtl/pt_tx_sched.sv - shares one PT2262 encoder between two requesters, replays bursts, watchdog
import pt_pkg::*;

module pt_tx_sched #(
    parameter int REPEATS    = 4,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [PT_CODE_W-1:0] req0_ad,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [PT_CODE_W-1:0] req1_ad,
    output logic                 req1_ready,
    output logic                 enc_ld,
    output logic [PT_CODE_W-1:0] enc_ad,
    input  logic                 enc_done,
    output logic                 busy,
    output logic                 grant_id,
    output logic                 err_timeout,
    output logic [15:0]          bursts_sent
);

    localparam int WW = $clog2(TIMEOUT);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [3:0]    REP_LAST = 4'(REPEATS - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    pt_state_e            state_q, state_d;
    logic [PT_CODE_W-1:0] enc_ad_q, enc_ad_d;
    logic                 grant_q, grant_d;
    logic [3:0]           rep_q, rep_d;
    logic [WW-1:0]        wd_q, wd_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [15:0]          bursts_q, bursts_d;
    logic                 err_q, err_d;
    logic [1:0]           gnt;

    // The encoder has no reset, so only grant once it reports idle
    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  ((state_q == IDLE) && enc_done),
        .req ({req1_valid, req0_valid}),
        .gnt (gnt)
    );

    always_comb begin
        state_d  = state_q;
        enc_ad_d = enc_ad_q;
        grant_d  = grant_q;
        rep_d    = rep_q;
        wd_d     = wd_q;
        gap_d    = gap_q;
        bursts_d = bursts_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt[0]) begin
                    enc_ad_d = req0_ad;
                    grant_d  = 1'b0;
                    rep_d    = REP_LAST;
                    state_d  = LOAD;
                end else if (gnt[1]) begin
                    enc_ad_d = req1_ad;
                    grant_d  = 1'b1;
                    rep_d    = REP_LAST;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                wd_d    = '0;
                state_d = ARM;
            end
            ARM: begin
                wd_d = wd_q + 1'b1;
                if (!enc_done) begin
                    state_d = SEND;
                end else if (wd_q == WD_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            SEND: begin
                wd_d = wd_q + 1'b1;
                if (enc_done) begin
                    if (rep_q != 4'd0) begin
                        rep_d   = rep_q - 1'b1;
                        state_d = LOAD;
                    end else begin
                        bursts_d = bursts_q + 1'b1;
                        gap_d    = '0;
                        state_d  = (GAP_CYCLES == 0) ? IDLE : GAP;
                    end
                end else if (wd_q == WD_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            enc_ad_q <= '0;
            grant_q  <= 1'b0;
            rep_q    <= '0;
            wd_q     <= '0;
            gap_q    <= '0;
            bursts_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            enc_ad_q <= enc_ad_d;
            grant_q  <= grant_d;
            rep_q    <= rep_d;
            wd_q     <= wd_d;
            gap_q    <= gap_d;
            bursts_q <= bursts_d;
            err_q    <= err_d;
        end
    end

    assign req0_ready  = gnt[0];
    assign req1_ready  = gnt[1];
    assign enc_ld      = (state_q == LOAD);
    assign enc_ad      = enc_ad_q;
    assign busy        = (state_q != IDLE);
    assign grant_id    = grant_q;
    assign err_timeout = err_q;
    assign bursts_sent = bursts_q;

endmodule

// File: tb/tb_pt_tx_sched.sv
// tb/tb_pt_tx_sched.sv - directed self-checking bench for pt_tx_sched
module tb_pt_tx_sched;
    import pt_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A: default parameters
    logic        req0_valid_a, req1_valid_a, req0_ready_a, req1_ready_a;
    logic [23:0] req0_ad_a, req1_ad_a, enc_ad_a;
    logic        enc_ld_a, enc_done_a, busy_a, grant_id_a, err_timeout_a;
    logic [15:0] bursts_a;

    // instance B: REPEATS=1, GAP_CYCLES=0
    logic        req0_valid_b, req1_valid_b, req0_ready_b, req1_ready_b;
    logic [23:0] req0_ad_b, req1_ad_b, enc_ad_b;
    logic        enc_ld_b, enc_done_b, busy_b, grant_id_b, err_timeout_b;
    logic [15:0] bursts_b;

    pt_tx_sched dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid_a), .req0_ad(req0_ad_a), .req0_ready(req0_ready_a),
        .req1_valid(req1_valid_a), .req1_ad(req1_ad_a), .req1_ready(req1_ready_a),
        .enc_ld(enc_ld_a), .enc_ad(enc_ad_a), .enc_done(enc_done_a),
        .busy(busy_a), .grant_id(grant_id_a), .err_timeout(err_timeout_a),
        .bursts_sent(bursts_a)
    );

    pt_tx_sched #(.REPEATS(1), .GAP_CYCLES(0), .TIMEOUT(1024)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid_b), .req0_ad(req0_ad_b), .req0_ready(req0_ready_b),
        .req1_valid(req1_valid_b), .req1_ad(req1_ad_b), .req1_ready(req1_ready_b),
        .enc_ld(enc_ld_b), .enc_ad(enc_ad_b), .enc_done(enc_done_b),
        .busy(busy_b), .grant_id(grant_id_b), .err_timeout(err_timeout_b),
        .bursts_sent(bursts_b)
    );

    // Encoder models: done stays high the cycle after ld, low until ld+513
    int   ecnt_a = 0, ecnt_b = 0;
    int   mode_a = 0;
    logic mdl_clr = 1'b0;
    always @(posedge clk) begin
        if (mdl_clr) ecnt_a <= 0;
        else if (enc_ld_a) ecnt_a <= 1;
        else if (ecnt_a == PT_FRAME_CYCLES) ecnt_a <= 0;
        else if (ecnt_a != 0) ecnt_a <= ecnt_a + 1;
        if (mdl_clr) ecnt_b <= 0;
        else if (enc_ld_b) ecnt_b <= 1;
        else if (ecnt_b == PT_FRAME_CYCLES) ecnt_b <= 0;
        else if (ecnt_b != 0) ecnt_b <= ecnt_b + 1;
    end
    assign enc_done_a = (mode_a == 1) ? 1'b1 : (mode_a == 2) ? 1'b0 : (ecnt_a <= 1);
    assign enc_done_b = (ecnt_b <= 1);

    // Event logs sampled on the falling edge
    logic        clr = 1'b0;
    int          ld_q[$], acc_q[$], accid_q[$], err_q[$], rise_q[$], idle_q[$];
    logic [23:0] ad_q[$];
    int          both_rdy;
    int          ld_b[$], acc_b[$], accid_b[$], rise_b[$], idle_b[$];
    logic        pd_a, pb_a, pd_b, pb_b;

    always @(negedge clk) begin
        if (clr) begin
            ld_q.delete(); acc_q.delete(); accid_q.delete(); err_q.delete();
            rise_q.delete(); idle_q.delete(); ad_q.delete(); both_rdy = 0;
            ld_b.delete(); acc_b.delete(); accid_b.delete(); rise_b.delete(); idle_b.delete();
        end else begin
            if (enc_ld_a) begin ld_q.push_back(cyc); ad_q.push_back(enc_ad_a); end
            if (req0_ready_a) begin acc_q.push_back(cyc); accid_q.push_back(0); end
            if (req1_ready_a) begin acc_q.push_back(cyc); accid_q.push_back(1); end
            if (req0_ready_a && req1_ready_a) both_rdy++;
            if (err_timeout_a) err_q.push_back(cyc);
            if (enc_done_a && !pd_a) rise_q.push_back(cyc);
            if (!busy_a && pb_a) idle_q.push_back(cyc);
            if (enc_ld_b) ld_b.push_back(cyc);
            if (req0_ready_b) begin acc_b.push_back(cyc); accid_b.push_back(0); end
            if (req1_ready_b) begin acc_b.push_back(cyc); accid_b.push_back(1); end
            if (enc_done_b && !pd_b) rise_b.push_back(cyc);
            if (!busy_b && pb_b) idle_b.push_back(cyc);
        end
        pd_a = enc_done_a; pb_a = busy_a; pd_b = enc_done_b; pb_b = busy_b;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_logs();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1; mdl_clr = 1'b1;
        @(posedge clk); #1 rst = 1'b0; mdl_clr = 1'b0;
    endtask

    int t0;

    initial begin
        rst = 1'b1;
        req0_valid_a = 0; req1_valid_a = 0; req0_ad_a = '0; req1_ad_a = '0;
        req0_valid_b = 0; req1_valid_b = 0; req0_ad_b = '0; req1_ad_b = '0;
        mdl_clr = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_ld", enc_ld_a, 0);
        chk("rst_ad", enc_ad_a, 0);
        chk("rst_grant", grant_id_a, 0);
        chk("rst_bursts", bursts_a, 0);
        chk("rst_err", err_timeout_a, 0);
        @(posedge clk); #1 rst = 1'b0; mdl_clr = 1'b0;

        // single burst
        clear_logs();
        req0_ad_a = 24'hA5A5A5; req0_valid_a = 1'b1;
        for (int i = 0; i < 20 && acc_q.size() < 1; i++) @(negedge clk);
        @(posedge clk); #1 req0_valid_a = 1'b0;
        for (int i = 0; i < 3000 && idle_q.size() < 1; i++) @(negedge clk);
        t0 = qget(acc_q, 0);
        chk("single_nacc", acc_q.size(), 1);
        chk("single_nld", ld_q.size(), 4);
        chk("single_ld0", qget(ld_q, 0), t0 + 1);
        chk("single_ld1", qget(ld_q, 1), t0 + 515);
        chk("single_ld2", qget(ld_q, 2), t0 + 1029);
        chk("single_ld3", qget(ld_q, 3), t0 + 1543);
        chk("single_lastdone", qget(rise_q, 3), t0 + 2056);
        chk("single_idle", qget(idle_q, 0), t0 + 2073);
        chk("single_bursts", bursts_a, 1);
        foreach (ad_q[i]) chk("single_ad_at_ld", ad_q[i], 24'hA5A5A5);
        chk("single_ad_end", enc_ad_a, 24'hA5A5A5);
        chk("single_grant", grant_id_a, 0);

        // contention
        do_reset();
        clear_logs();
        req0_ad_a = 24'h111111; req1_ad_a = 24'h222222;
        req0_valid_a = 1'b1; req1_valid_a = 1'b1;
        for (int i = 0; i < 9000 && acc_q.size() < 4; i++) @(negedge clk);
        @(posedge clk); #1 req0_valid_a = 1'b0; req1_valid_a = 1'b0;
        for (int i = 0; i < 2500 && idle_q.size() < 4; i++) @(negedge clk);
        t0 = qget(acc_q, 0);
        chk("cont_nacc", acc_q.size(), 4);
        chk("cont_id0", qget(accid_q, 0), 0);
        chk("cont_id1", qget(accid_q, 1), 1);
        chk("cont_id2", qget(accid_q, 2), 0);
        chk("cont_id3", qget(accid_q, 3), 1);
        chk("cont_both_ready", both_rdy, 0);
        chk("cont_ld4", qget(ld_q, 4), t0 + 2074);
        chk("cont_ad_last", enc_ad_a, 24'h222222);
        chk("cont_bursts", bursts_a, 4);

        // stuck encoder
        do_reset();
        clear_logs();
        mode_a = 1;
        req0_ad_a = 24'h0F0F0F; req0_valid_a = 1'b1;
        for (int i = 0; i < 20 && acc_q.size() < 1; i++) @(negedge clk);
        @(posedge clk); #1 req0_valid_a = 1'b0;
        for (int i = 0; i < 1100 && err_q.size() < 1; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        t0 = qget(acc_q, 0);
        chk("stuck_nerr", err_q.size(), 1);
        chk("stuck_err_cyc", qget(err_q, 0), t0 + 1026);
        chk("stuck_nld", ld_q.size(), 1);
        chk("stuck_busy", busy_a, 0);
        chk("stuck_bursts", bursts_a, 0);
        chk("stuck_ad_held", enc_ad_a, 24'h0F0F0F);
        mode_a = 0;

        // reset mid-burst
        do_reset();
        clear_logs();
        req0_ad_a = 24'h123456; req0_valid_a = 1'b1;
        for (int i = 0; i < 20 && acc_q.size() < 1; i++) @(negedge clk);
        @(posedge clk); #1 req0_valid_a = 1'b0;
        for (int i = 0; i < 600 && ld_q.size() < 2; i++) @(negedge clk);
        repeat (100) @(negedge clk);
        chk("mid_busy_before", busy_a, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ld", enc_ld_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_ad", enc_ad_a, 0);
        mode_a = 2;
        @(posedge clk); #1 rst = 1'b0;
        clear_logs();
        req0_valid_a = 1'b1;
        repeat (50) @(negedge clk);
        chk("mid_no_grant", acc_q.size(), 0);
        mode_a = 1;
        for (int i = 0; i < 10 && acc_q.size() < 1; i++) @(negedge clk);
        chk("mid_grant_after_done", acc_q.size(), 1);
        @(posedge clk); #1 req0_valid_a = 1'b0;
        mode_a = 0;
        do_reset();

        // REPEATS=1, GAP_CYCLES=0 corner on instance B
        clear_logs();
        req0_ad_b = 24'h000001; req0_valid_b = 1'b1;
        for (int i = 0; i < 20 && acc_b.size() < 1; i++) @(negedge clk);
        @(posedge clk); #1 req0_valid_b = 1'b0;
        req1_ad_b = 24'h000002; req1_valid_b = 1'b1;
        for (int i = 0; i < 700 && acc_b.size() < 2; i++) @(negedge clk);
        @(posedge clk); #1 req1_valid_b = 1'b0;
        for (int i = 0; i < 700 && idle_b.size() < 2; i++) @(negedge clk);
        t0 = qget(acc_b, 0);
        chk("corner_ld0", qget(ld_b, 0), t0 + 1);
        chk("corner_done", qget(rise_b, 0), t0 + 514);
        chk("corner_idle", qget(idle_b, 0), t0 + 515);
        chk("corner_acc2", qget(acc_b, 1), t0 + 515);
        chk("corner_acc2_id", qget(accid_b, 1), 1);
        chk("corner_ld1", qget(ld_b, 1), t0 + 516);
        chk("corner_nld", ld_b.size(), 2);
        chk("corner_bursts", bursts_b, 2);

        // bursts_sent wrap
        do_reset();
        clear_logs();
        @(negedge clk);
        force dut_a.bursts_q = 16'hFFFF;
        @(negedge clk);
        release dut_a.bursts_q;
        @(negedge clk);
        chk("wrap_preload", bursts_a, 16'hFFFF);
        req0_ad_a = 24'h555555; req0_valid_a = 1'b1;
        for (int i = 0; i < 20 && acc_q.size() < 1; i++) @(negedge clk);
        @(posedge clk); #1 req0_valid_a = 1'b0;
        for (int i = 0; i < 3000 && idle_q.size() < 1; i++) @(negedge clk);
        chk("wrap_done", idle_q.size(), 1);
        chk("wrap_bursts", bursts_a, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
